// File: rtl/barrel_shifter.sv
// Registered WIDTH-bit barrel shifter/rotator built from log2(WIDTH) power-of-two mux stages.
// Define BARREL_PIPE2_EN to add a register after the shift-by-1/shift-by-2 stages (latency 2).

module barrel_stage #(
    parameter int WIDTH = 16,
    parameter int SH    = 1
) (
    input  logic [WIDTH-1:0] d,
    input  logic [2:0]       mode,
    input  logic             en,
    output logic [WIDTH-1:0] q
);
    always_comb begin
        q = d;
        if (en) begin
            case (mode)
                3'b000:  q = (d << SH) | (d >> (WIDTH - SH));
                3'b001:  q = (d >> SH) | (d << (WIDTH - SH));
                3'b010:  q = d << SH;
                3'b011:  q = d >> SH;
                3'b100:  q = $unsigned($signed(d) >>> SH);
                default: q = d;
            endcase
        end
    end
endmodule

module barrel_shifter #(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [SHW-1:0]   C,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] O,
    output logic             out_valid
);
`ifdef BARREL_PIPE2_EN
    localparam bit PIPE2 = 1'b1;
`else
    localparam bit PIPE2 = 1'b0;
`endif
    localparam int STAGES = PIPE2 ? 2 : 1;
    // Register cut sits after the shift-by-2 stage (or after the only stage when WIDTH=2).
    localparam int CUT    = (SHW > 1) ? 1 : 0;

    logic [WIDTH-1:0] sd [SHW+1];
    logic [WIDTH-1:0] so [SHW];
    logic [2:0]       sm [SHW];
    logic [SHW-1:0]   ab;
    logic [STAGES:0]  vld_pipe;

    assign sd[0] = A;

    for (genvar k = 0; k < SHW; k++) begin : g_stg
        barrel_stage #(.WIDTH(WIDTH), .SH(1 << k)) u_stage (
            .d    (sd[k]),
            .mode (sm[k]),
            .en   (ab[k]),
            .q    (so[k])
        );

        // Stages past the cut see mode/amount delayed to line up with their data.
        if (PIPE2 && k > CUT) begin : g_late
            logic [2:0] m_q;
            logic       a_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    m_q <= '0;
                    a_q <= 1'b0;
                end else begin
                    m_q <= mode;
                    a_q <= C[k];
                end
            end
            assign sm[k] = m_q;
            assign ab[k] = a_q;
        end else begin : g_early
            assign sm[k] = mode;
            assign ab[k] = C[k];
        end

        if (PIPE2 && k == CUT) begin : g_cut
            logic [WIDTH-1:0] d_q;
            always_ff @(posedge clk) begin
                if (rst) d_q <= '0;
                else     d_q <= so[k];
            end
            assign sd[k+1] = d_q;
        end else begin : g_pass
            assign sd[k+1] = so[k];
        end
    end

    assign vld_pipe[0] = in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe[STAGES:1] <= '0;
            O                  <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            if (vld_pipe[STAGES-1]) O <= sd[SHW];
        end
    end

    assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_barrel_shifter.sv
// Directed and random checks of barrel_shifter; latency follows BARREL_PIPE2_EN.
`timescale 1ns/1ps
module tb_barrel_shifter;
`ifdef BARREL_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] A;
    logic [3:0]  C;
    logic [2:0]  mode;
    logic [15:0] O;
    logic        out_valid;

    int n_chk  = 0;
    int n_fail = 0;

    // Expected pipeline: slot k is what should reach the output k edges later.
    logic        mv [LAT+1];
    logic [15:0] md [LAT+1];
    logic [15:0] exp_o;

    barrel_shifter #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .C         (C),
        .mode      (mode),
        .O         (O),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_shift(input logic [15:0] a, input logic [3:0] c,
                                              input logic [2:0] m);
        logic [15:0] r;
        int          ci;
        ci = int'(c);
        r  = '0;
        for (int i = 0; i < 16; i++) begin
            case (m)
                3'd0: r[(i + ci) % 16] = a[i];
                3'd1: r[i] = a[(i + ci) % 16];
                3'd2: r[i] = (i >= ci) ? a[i - ci] : 1'b0;
                3'd3: r[i] = (i + ci < 16) ? a[i + ci] : 1'b0;
                3'd4: r[i] = (i + ci < 16) ? a[i + ci] : a[15];
                default: r[i] = a[i];
            endcase
        end
        return r;
    endfunction

    // One clock: advance the expected pipeline with the currently driven inputs, then compare.
    task automatic tick(input string tag, input logic [15:0] e);
        logic v0;
        v0 = in_valid;
        @(posedge clk);
        #1;
        if (rst) begin
            for (int k = 1; k <= LAT; k++) begin
                mv[k] = 1'b0;
                md[k] = '0;
            end
            exp_o = '0;
        end else begin
            for (int k = LAT; k >= 2; k--) begin
                mv[k] = mv[k-1];
                md[k] = md[k-1];
            end
            mv[1] = v0;
            md[1] = e;
            if (mv[LAT]) exp_o = md[LAT];
        end
        chk({tag, ".o"}, O, exp_o);
        chk({tag, ".vld"}, {15'd0, out_valid}, {15'd0, mv[LAT]});
    endtask

    task automatic op(input string tag, input logic [15:0] a, input logic [3:0] c,
                      input logic [2:0] m, input logic [15:0] e);
        A = a; C = c; mode = m; in_valid = 1'b1;
        tick(tag, e);
    endtask

    task automatic idle(input string tag, input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick(tag, 16'h0);
    endtask

    initial begin
        exp_o = '0;
        for (int k = 0; k <= LAT; k++) begin
            mv[k] = 1'b0;
            md[k] = '0;
        end
        rst = 1'b1; in_valid = 1'b1; A = 16'hFFFF; C = 4'd3; mode = 3'd0;
        tick("rst0", 16'h0);
        tick("rst1", 16'h0);
        rst = 1'b0;

        op("rol_c0", 16'hAAAA, 4'd0, 3'd0, 16'hAAAA);
        op("rol_c1", 16'hAAAA, 4'd1, 3'd0, 16'h5555);
        op("rol4",   16'h8001, 4'd4, 3'd0, 16'h0018);
        op("ror4",   16'h8001, 4'd4, 3'd1, 16'h1800);
        op("sll4",   16'h8001, 4'd4, 3'd2, 16'h0010);
        op("srl4",   16'h8001, 4'd4, 3'd3, 16'h0800);
        op("sra4",   16'h8001, 4'd4, 3'd4, 16'hF800);
        op("rsv7",   16'h8001, 4'd4, 3'd7, 16'h8001);
        op("rsv5",   16'h1234, 4'd9, 3'd5, 16'h1234);
        op("rol15",  16'h0001, 4'd15, 3'd0, 16'h8000);
        op("sra15",  16'h8000, 4'd15, 3'd4, 16'hFFFF);
        op("srl15",  16'h8000, 4'd15, 3'd3, 16'h0001);
        op("sll15",  16'hFFFF, 4'd15, 3'd2, 16'h8000);
        op("sra_c0", 16'h8000, 4'd0, 3'd4, 16'h8000);
        op("ror15",  16'h0001, 4'd15, 3'd1, 16'h0002);
        idle("flush0", LAT + 1);

        op("gap_a", 16'h00F0, 4'd4, 3'd2, 16'h0F00);
        idle("gap", 1);
        op("gap_b", 16'h00F0, 4'd4, 3'd3, 16'h000F);
        idle("flush1", LAT + 1);

        op("pre_rst", 16'h1111, 4'd1, 3'd2, 16'h2222);
        rst = 1'b1; A = 16'hFFFF; C = 4'd1;
        tick("mid_rst", 16'h0);
        rst = 1'b0;
        idle("post_rst", LAT + 1);

        for (int i = 0; i < 1000; i++) begin
            A        = 16'($urandom);
            C        = 4'($urandom_range(0, 15));
            mode     = 3'($urandom_range(0, 7));
            in_valid = ($urandom_range(0, 7) != 0);
            tick("rnd", ref_shift(A, C, mode));
        end
        idle("flush2", LAT + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/barrel_shifter.md
Name: barrel_shifter

Overview:
- Registered 16-bit barrel shifter/rotator for the datapath.
- Shifts or rotates operand A by a 4-bit amount C in one of five modes.
- Result is presented on O after a fixed clocked latency, with a valid flag.
- Built as log2(WIDTH) mux stages (shift by 1, 2, 4, 8), followed by an output register.

Parameters:
- WIDTH, 16, data width. Must be a power of two, at least 2.
- SHW, log2(WIDTH) = 4, shift-amount width. Localparam derived from WIDTH; not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  A/C/mode are sampled when high.
- A  input  WIDTH  operand.
- C  input  SHW  shift/rotate amount, 0..WIDTH-1.
- mode  input  3  operation select.
- O  output  WIDTH  registered result.
- out_valid  output  1  O holds a new result this cycle.

Behaviour:
- Reset (rst=1 at a rising edge): O=0, out_valid=0, all pipeline registers cleared. Reset wins over in_valid on the same edge. Asserting reset mid-operation discards any in-flight result.
- Mode encoding:
  - 000 ROL: rotate left; bits leaving the MSB enter at the LSB.
  - 001 ROR: rotate right.
  - 010 SLL: logical left; fill with 0.
  - 011 SRL: logical right; fill with 0.
  - 100 SRA: arithmetic right; fill with A[WIDTH-1].
  - 101-111: reserved; O=A, no shift.
- C=0 yields O=A in every mode.
- C is unsigned; the maximum amount is WIDTH-1. No amount produces a full clear except through shifting (e.g. SLL by 15 keeps only bit 0, moved to bit 15).
- Latency: 1 cycle. A result sampled at edge N (in_valid=1) appears on O with out_valid=1 after edge N.
- in_valid=0 at an edge: out_valid=0 next cycle; O holds its previous value.
- Throughput: one operation per cycle. No backpressure, no stall input.
- Shift logic is purely combinational between the input sample and the output register. No combinational path from inputs to outputs.

Optional Feature:
- Macro: BARREL_PIPE2_EN.
- When defined:
  - A register stage is inserted after the shift-by-1 and shift-by-2 stages.
  - The mode and partial-amount bits for the remaining stages are carried with the data.
  - Latency becomes 2 cycles; out_valid is delayed identically. Throughput remains 1/cycle.
  - Reset clears both stages.
- When undefined: single-stage behaviour exactly as above (latency 1).
- Results are bit-identical in both builds; only timing differs.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, A=0xFFFF -> O=0x0000, out_valid=0. Assert rst mid-stream -> next cycle O=0, out_valid=0.
- ROL, A=0xAAAA: C=0 -> O=0xAAAA; C=1 -> O=0x5555; back-to-back issue gives results on consecutive cycles.
- A=0x8001, C=4, per mode:
  - ROL -> 0x0018
  - ROR -> 0x1800
  - SLL -> 0x0010
  - SRL -> 0x0800
  - SRA -> 0xF800
  - mode=111 -> 0x8001
- Boundaries at C=15:
  - ROL 0x0001 -> 0x8000
  - SRA 0x8000 -> 0xFFFF
  - SRL 0x8000 -> 0x0001
  - SLL 0xFFFF -> 0x8000
- Valid handling: in_valid pattern 1,0,1 -> out_valid 1,0,1 one cycle later (two with BARREL_PIPE2_EN); O holds the prior result during the gap.
- Randomized comparison: 1000 random A/C/mode vs. reference model with the correct latency, in both BARREL_PIPE2_EN builds.
